// File: rtl/branch_predictor_if.sv
// Signal bundle between the MIPS pipeline (IF lookup, EX/MEM resolve) and the
// branch target buffer.
interface branch_predictor_if;
    logic        en;
    logic [31:0] lkup_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        pred_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_npc;
    logic        mispredict;
    logic [31:0] correct_npc;
    logic        flush_all;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output en, lkup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_npc, flush_all,
        input  pred_taken, pred_npc, pred_hit, mispredict, correct_npc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  en, lkup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_npc, flush_all,
        output pred_taken, pred_npc, pred_hit, mispredict, correct_npc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// zero-latency lookup, resolve-time training and branch/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int CTR_W     = 2,
    parameter int ALLOC_CTR = 2 ** (CTR_W - 1)
) (
    input logic                 CLK,
    input logic                 nRST,
    branch_predictor_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ALLOC_CTR);

    // Table storage: only the valid bits need a reset value.
    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] valid_next;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    // ---------------- lookup (IF stage) ----------------
    logic [IDX_W-1:0] lkup_idx;
    logic [TAG_W-1:0] lkup_tag;
    logic [31:0]      lkup_seq_npc;
    logic             lkup_hit;
    logic             lkup_taken;

    assign lkup_idx     = bus.lkup_pc[IDX_W+1:2];
    assign lkup_tag     = bus.lkup_pc[31:IDX_W+2];
    assign lkup_seq_npc = bus.lkup_pc + 32'd4;
    assign lkup_hit     = valid_reg[lkup_idx] && (tag_mem[lkup_idx] == lkup_tag);
    assign lkup_taken   = lkup_hit && ctr_mem[lkup_idx][CTR_W-1];

    assign bus.pred_hit   = lkup_hit;
    assign bus.pred_taken = lkup_taken;
    assign bus.pred_npc   = lkup_taken ? target_mem[lkup_idx] : lkup_seq_npc;

    // ---------------- resolve (EX/MEM stage) ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      upd_correct_npc;
    logic             upd_hit;
    logic             upd_mispredict;
    logic             tbl_we;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    assign upd_idx         = bus.upd_pc[IDX_W+1:2];
    assign upd_tag         = bus.upd_pc[31:IDX_W+2];
    assign upd_correct_npc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + 32'd4);
    assign upd_hit         = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign upd_mispredict  = bus.upd_valid && (bus.upd_pred_npc != upd_correct_npc);
    assign tbl_we          = bus.en && bus.upd_valid && !bus.flush_all;
    assign ctr_cur         = ctr_mem[upd_idx];

    assign bus.mispredict  = upd_mispredict;
    assign bus.correct_npc = upd_correct_npc;

    // Saturate explicitly at both ends instead of relying on wrap detection.
    always_comb begin
        ctr_next = ctr_cur;
        if (bus.upd_taken) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_next = ctr_cur + CTR_W'(1);
            end
        end else if (ctr_cur != '0) begin
            ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    // Per-entry valid: flush wins, then taken-miss allocation sets the bit.
    // Flush is not gated by en so a pipeline-wide invalidate is never lost.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
        logic entry_alloc;
        assign entry_alloc = tbl_we && !upd_hit && bus.upd_taken &&
                             (upd_idx == IDX_W'(gi));
        assign valid_next[gi] = bus.flush_all ? 1'b0
                              : (entry_alloc ? 1'b1 : valid_reg[gi]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (tbl_we) begin
            if (upd_hit) begin
                ctr_mem[upd_idx] <= ctr_next;
                if (bus.upd_taken) begin
                    target_mem[upd_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                tag_mem[upd_idx]    <= upd_tag;
                target_mem[upd_idx] <= bus.upd_target;
                ctr_mem[upd_idx]    <= CTR_INIT;
            end
        end
    end

    // ---------------- statistics ----------------
    // Counted on every advancing resolve, even while the table is being flushed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else if (bus.en && bus.upd_valid) begin
            stat_branches_reg <= stat_branches_reg + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign bus.stat_branches    = stat_branches_reg;
    assign bus.stat_mispredicts = stat_mispredicts_reg;

    // The carried direction bit is redundant with the carried next PC.
    logic unused_pred_taken;
    assign unused_pred_taken = bus.upd_pred_taken;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, CTR_W=2): one task per
// scenario, hand-computed expectations, one line printed per update.
module tb_branch_predictor;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    int   exp_br;
    int   exp_mp;

    branch_predictor_if bif ();

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .ALLOC_CTR(2)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic [31:0] pnpc);
        logic [31:0] corr;
        corr = taken ? target : pc + 32'd4;
        bif.upd_valid      = 1'b1;
        bif.upd_pc         = pc;
        bif.upd_taken      = taken;
        bif.upd_target     = target;
        bif.upd_pred_npc   = pnpc;
        bif.upd_pred_taken = (pnpc != pc + 32'd4);
        if (bif.en) begin
            exp_br++;
            if (pnpc != corr) exp_mp++;
        end
        @(posedge clk);
        #1;
        bif.upd_valid = 1'b0;
        bif.flush_all = 1'b0;
        @(negedge clk);
        $display("update pc=%h taken=%0b target=%h pred_npc=%h en=%0b", pc, taken, target, pnpc, bif.en);
    endtask

    task automatic test_reset;
        bif.lkup_pc = 32'h0000_0040;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", bif.pred_hit); end
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b want 0", bif.pred_taken); end
        checks++; if (bif.pred_npc !== 32'h0000_0044) begin errors++; $display("FAIL reset_npc got %h want 00000044", bif.pred_npc); end
        checks++; if (bif.stat_branches !== 32'd0) begin errors++; $display("FAIL reset_branches got %0d want 0", bif.stat_branches); end
        checks++; if (bif.stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_mispredicts got %0d want 0", bif.stat_mispredicts); end
        checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL idle_mispredict got %0b want 0", bif.mispredict); end
        // 32-bit wrap of the sequential next PC
        bif.lkup_pc    = 32'hFFFF_FFFC;
        bif.upd_pc     = 32'hFFFF_FFFC;
        bif.upd_taken  = 1'b0;
        #1;
        checks++; if (bif.pred_npc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pred_npc got %h want 00000000", bif.pred_npc); end
        checks++; if (bif.correct_npc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_correct_npc got %h want 00000000", bif.correct_npc); end
        @(negedge clk);
    endtask

    task automatic test_allocate;
        bif.lkup_pc      = 32'h0000_0040;
        bif.upd_valid    = 1'b1;
        bif.upd_pc       = 32'h0000_0040;
        bif.upd_taken    = 1'b1;
        bif.upd_target   = 32'h0000_0100;
        bif.upd_pred_npc = 32'h0000_0044;
        #1;
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b want 1", bif.mispredict); end
        checks++; if (bif.correct_npc !== 32'h0000_0100) begin errors++; $display("FAIL alloc_correct_npc got %h want 00000100", bif.correct_npc); end
        do_update(32'h40, 1'b1, 32'h100, 32'h44);
        checks++; if (bif.pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %0b want 1", bif.pred_hit); end
        checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken got %0b want 1", bif.pred_taken); end
        checks++; if (bif.pred_npc !== 32'h0000_0100) begin errors++; $display("FAIL alloc_npc got %h want 00000100", bif.pred_npc); end
        checks++; if (bif.stat_branches !== 32'd1) begin errors++; $display("FAIL alloc_branches got %0d want 1", bif.stat_branches); end
        checks++; if (bif.stat_mispredicts !== 32'd1) begin errors++; $display("FAIL alloc_mispredicts got %0d want 1", bif.stat_mispredicts); end
    endtask

    task automatic test_counter;
        // ctr trajectory from 2: 1,0,0,1,2,3,3,2,1,2
        logic        tk   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] tgt  [10] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h140};
        logic [31:0] pn   [10] = '{32'h100, 32'h44, 32'h44, 32'h44, 32'h44, 32'h100, 32'h100, 32'h100, 32'h100, 32'h44};
        logic        etk  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] enpc [10] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h100, 32'h100, 32'h100, 32'h100, 32'h44, 32'h140};
        bif.lkup_pc = 32'h0000_0040;
        for (int i = 0; i < 10; i++) begin
            do_update(32'h40, tk[i], tgt[i], pn[i]);
            checks++; if (bif.pred_taken !== etk[i]) begin errors++; $display("FAIL ctr_step%0d_taken got %0b want %0b", i, bif.pred_taken, etk[i]); end
            checks++; if (bif.pred_npc !== enpc[i]) begin errors++; $display("FAIL ctr_step%0d_npc got %h want %h", i, bif.pred_npc, enpc[i]); end
        end
        checks++; if (bif.pred_hit !== 1'b1) begin errors++; $display("FAIL ctr_hit got %0b want 1", bif.pred_hit); end
    endtask

    task automatic test_alias;
        bif.lkup_pc = 32'h0000_0080;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL alias_hit_before got %0b want 0", bif.pred_hit); end
        checks++; if (bif.pred_npc !== 32'h0000_0084) begin errors++; $display("FAIL alias_npc_before got %h want 00000084", bif.pred_npc); end
        do_update(32'h80, 1'b1, 32'h200, 32'h84);
        checks++; if (bif.pred_npc !== 32'h0000_0200) begin errors++; $display("FAIL alias_new_npc got %h want 00000200", bif.pred_npc); end
        bif.lkup_pc = 32'h0000_0040;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got %0b want 0", bif.pred_hit); end
        // Not-taken miss must not allocate
        do_update(32'h44, 1'b0, 32'h999, 32'h48);
        bif.lkup_pc = 32'h0000_0044;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_hit got %0b want 0", bif.pred_hit); end
    endtask

    task automatic test_same_cycle;
        bif.lkup_pc      = 32'h0000_0080;
        bif.upd_valid    = 1'b1;
        bif.upd_pc       = 32'h0000_0080;
        bif.upd_taken    = 1'b1;
        bif.upd_target   = 32'h0000_0300;
        bif.upd_pred_npc = 32'h0000_0200;
        exp_br++;
        exp_mp++;
        #1;
        checks++; if (bif.pred_npc !== 32'h0000_0200) begin errors++; $display("FAIL same_cycle_pre_npc got %h want 00000200", bif.pred_npc); end
        @(posedge clk);
        #1;
        bif.upd_valid = 1'b0;
        @(negedge clk);
        $display("update pc=00000080 taken=1 target=00000300 pred_npc=00000200 en=1");
        checks++; if (bif.pred_npc !== 32'h0000_0300) begin errors++; $display("FAIL same_cycle_post_npc got %h want 00000300", bif.pred_npc); end
        checks++; if (bif.stat_branches !== 32'(exp_br)) begin errors++; $display("FAIL same_cycle_branches got %0d want %0d", bif.stat_branches, exp_br); end
        checks++; if (bif.stat_mispredicts !== 32'(exp_mp)) begin errors++; $display("FAIL same_cycle_mispredicts got %0d want %0d", bif.stat_mispredicts, exp_mp); end
    endtask

    task automatic test_flush;
        do_update(32'h48, 1'b1, 32'h400, 32'h4C);
        bif.lkup_pc = 32'h0000_0048;
        #1;
        checks++; if (bif.pred_hit !== 1'b1) begin errors++; $display("FAIL flush_pre_hit got %0b want 1", bif.pred_hit); end
        bif.flush_all = 1'b1;
        do_update(32'h4C, 1'b1, 32'h500, 32'h50);
        bif.lkup_pc = 32'h0000_0048;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_hit_48 got %0b want 0", bif.pred_hit); end
        bif.lkup_pc = 32'h0000_0080;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_hit_80 got %0b want 0", bif.pred_hit); end
        bif.lkup_pc = 32'h0000_004C;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL flush_hit_4c got %0b want 0", bif.pred_hit); end
        checks++; if (bif.stat_branches !== 32'(exp_br)) begin errors++; $display("FAIL flush_branches got %0d want %0d", bif.stat_branches, exp_br); end
        checks++; if (bif.stat_mispredicts !== 32'(exp_mp)) begin errors++; $display("FAIL flush_mispredicts got %0d want %0d", bif.stat_mispredicts, exp_mp); end
    endtask

    task automatic test_en_low;
        do_update(32'h40, 1'b1, 32'h100, 32'h44);
        bif.en           = 1'b0;
        bif.lkup_pc      = 32'h0000_0040;
        bif.upd_valid    = 1'b1;
        bif.upd_pc       = 32'h0000_0040;
        bif.upd_taken    = 1'b0;
        bif.upd_target   = 32'h0000_0000;
        bif.upd_pred_npc = 32'h0000_0100;
        #1;
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL en_low_mispredict got %0b want 1", bif.mispredict); end
        checks++; if (bif.correct_npc !== 32'h0000_0044) begin errors++; $display("FAIL en_low_correct_npc got %h want 00000044", bif.correct_npc); end
        @(posedge clk);
        #1;
        bif.upd_valid = 1'b0;
        @(negedge clk);
        $display("update pc=00000040 taken=0 target=00000000 pred_npc=00000100 en=0");
        checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL en_low_taken got %0b want 1", bif.pred_taken); end
        checks++; if (bif.stat_branches !== 32'(exp_br)) begin errors++; $display("FAIL en_low_branches got %0d want %0d", bif.stat_branches, exp_br); end
        checks++; if (bif.stat_mispredicts !== 32'(exp_mp)) begin errors++; $display("FAIL en_low_mispredicts got %0d want %0d", bif.stat_mispredicts, exp_mp); end
        // en low also blocks allocation
        do_update(32'h60, 1'b1, 32'h600, 32'h64);
        bif.lkup_pc = 32'h0000_0060;
        #1;
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL en_low_alloc_hit got %0b want 0", bif.pred_hit); end
        bif.en = 1'b1;
    endtask

    task automatic test_async_reset;
        bif.lkup_pc      = 32'h0000_0040;
        bif.upd_valid    = 1'b1;
        bif.upd_pc       = 32'h0000_0040;
        bif.upd_taken    = 1'b1;
        bif.upd_target   = 32'h0000_0100;
        bif.upd_pred_npc = 32'h0000_0100;
        #1;
        checks++; if (bif.pred_hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit got %0b want 1", bif.pred_hit); end
        #1;
        nrst = 1'b0;
        #1;
        checks++; if (bif.stat_branches !== 32'd0) begin errors++; $display("FAIL async_branches got %0d want 0", bif.stat_branches); end
        checks++; if (bif.stat_mispredicts !== 32'd0) begin errors++; $display("FAIL async_mispredicts got %0d want 0", bif.stat_mispredicts); end
        checks++; if (bif.pred_hit !== 1'b0) begin errors++; $display("FAIL async_hit got %0b want 0", bif.pred_hit); end
        checks++; if (bif.pred_npc !== 32'h0000_0044) begin errors++; $display("FAIL async_npc got %h want 00000044", bif.pred_npc); end
        bif.upd_valid = 1'b0;
        @(negedge clk);
        #2;
        nrst = 1'b1;
        @(negedge clk);
        exp_br = 0;
        exp_mp = 0;
        checks++; if (bif.stat_branches !== 32'(exp_br)) begin errors++; $display("FAIL post_reset_branches got %0d want 0", bif.stat_branches); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_br = 0;
        exp_mp = 0;
        nrst               = 1'b0;
        bif.en             = 1'b1;
        bif.lkup_pc        = '0;
        bif.upd_valid      = 1'b0;
        bif.upd_pc         = '0;
        bif.upd_taken      = 1'b0;
        bif.upd_target     = '0;
        bif.upd_pred_taken = 1'b0;
        bif.upd_pred_npc   = '0;
        bif.flush_all      = 1'b0;
        #12;
        nrst = 1'b1;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_flush();
        test_en_low();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage MIPS pipeline.
- The IF stage looks up the current PC combinationally and receives a predicted next PC. The EX/MEM stage returns the resolved outcome, which trains the table and flags mispredictions for pipeline flush.
- Generalises the fixed PC+4 / late-resolve next-PC selection into a configurable-depth, configurable-counter-width predictor with statistics counters.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width in bits, 1..4
ALLOC_CTR, 2 (i.e. 2^(CTR_W-1)), counter value written on allocation (weakly taken)

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
en  in  1  pipeline advance qualifier; updates and stats only when high
lkup_pc  in  32  IF-stage PC (cpc)
pred_taken  out  1  lookup hit and counter MSB set
pred_npc  out  32  pred_taken ? stored target : lkup_pc+4
pred_hit  out  1  valid entry with matching tag
upd_valid  in  1  resolved control-flow instruction present at EX/MEM
upd_pc  in  32  PC of resolved instruction
upd_taken  in  1  actual direction (1 for J/JAL/JR)
upd_target  in  32  actual target when taken
upd_pred_taken  in  1  prediction carried down the pipe for this instruction
upd_pred_npc  in  32  predicted next PC carried down the pipe
mispredict  out  1  combinational flush request
correct_npc  out  32  upd_taken ? upd_target : upd_pc+4
flush_all  in  1  synchronous invalidate of all entries
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Per entry: valid, tag, target[31:0], ctr[CTR_W-1:0].
- Lookup is combinational, zero latency. pred_hit = valid[idx] && tag match. pred_taken = pred_hit && ctr[CTR_W-1].
- Lookup reflects state before any same-cycle update; no write-through bypass.
- mispredict = upd_valid && (upd_pred_npc != correct_npc). It is asserted regardless of en. correct_npc is always driven.
- Update happens at the clock edge when en && upd_valid && !flush_all:
  - Hit: ctr saturating +1 if taken, -1 if not taken. It holds at all-ones and at 0 (no wrap). If taken, the target is overwritten with upd_target.
  - Miss and taken: allocate, overwriting any existing entry at that index. Set valid=1, the new tag, target=upd_target, ctr=ALLOC_CTR.
  - Miss and not taken: no table change.
- Stats update when en && upd_valid, including during flush_all:
  - stat_branches increments by 1.
  - stat_mispredicts increments by 1 when mispredict is high.
  - Both counters wrap 0xFFFFFFFF→0.
- flush_all clears every valid bit at the next edge and wins over a same-cycle update to the table. Stats are unaffected by flush_all.
- en low: table and stats hold; lookup outputs still track lkup_pc.
- Reset (async, any time, including mid-update): all valid=0, stats=0. Tag, target and ctr contents are don't-care after reset. Outputs after reset: pred_hit=0, pred_taken=0, pred_npc=lkup_pc+4.
- Arithmetic: all +4 operations are 32-bit modulo; 0xFFFFFFFC+4 = 0x00000000.
- RTL has no initial blocks. Counter saturation is handled explicitly, without relying on overflow.

Test Plan (ENTRIES=16, CTR_W=2):
1. Reset, then lkup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_npc=0x00000044; both stats=0.
2. Update pc=0x40, taken, target=0x100, pred_npc=0x44, en=1 -> mispredict=1, correct_npc=0x100. Next cycle lookup 0x40: hit=1, taken=1, pred_npc=0x100; stat_branches=1, stat_mispredicts=1.
3. Two not-taken updates on pc=0x40 -> ctr goes 2→1→0, pred_taken=0. A third not-taken update leaves ctr=0. Four taken updates -> ctr saturates at 3. One not-taken update then yields ctr=2, still predicted taken.
4. Alias: entry for 0x40 present; lookup 0x80 (same index 0, different tag) -> pred_hit=0. A taken update at 0x80 with target 0x200 replaces the entry; lookup 0x40 -> pred_hit=0.
5. Same-cycle update and lookup of 0x40 -> lookup shows the pre-update ctr/target. flush_all together with a taken update -> next cycle all pred_hit=0 and stat_branches increments.
6. en=0 with upd_valid=1 and mispredict -> mispredict=1, but table and stats unchanged. Assert nRST mid-sequence -> stats=0 and pred_hit=0 immediately, without waiting for a clock edge.
